// File: rtl/led_effect_controller.sv
// Sequencer for the 8-LED effect board: synchronizes two buttons and steps the
// LED pattern once per prescaled tick according to the selected effect mode.
module led_effect_controller #(
  parameter int N        = 8,
  parameter int TICK_DIV = 12500000,
  parameter int DIV_W    = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_mode,
  input  logic         btn_run,
  output logic [N-1:0] led,
  output logic [2:0]   mode,
  output logic         running,
  output logic         step
);

  typedef enum logic [2:0] {
    M_COUNT  = 3'd0,
    M_SHL    = 3'd1,
    M_SHR    = 3'd2,
    M_BOUNCE = 3'd3,
    M_BLINK  = 3'd4
  } mode_e;

  localparam logic [N-1:0]     LED_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]     LED_MSB  = {1'b1, {(N-1){1'b0}}};
  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  mode_e            mode_q;
  mode_e            mode_nxt;
  logic [N-1:0]     led_q;
  logic [N-1:0]     led_nxt;
  logic [N-1:0]     led_init;
  logic [DIV_W-1:0] cnt_q;
  logic             dir_right_q;
  logic             dir_nxt;
  logic             running_q;
  logic             step_q;

  logic [1:0] mode_sync;
  logic [1:0] run_sync;
  logic       mode_prev;
  logic       run_prev;
  logic       mode_press;
  logic       run_press;
  logic       tick;

  assign mode_press = mode_sync[1] & ~mode_prev;
  assign run_press  = run_sync[1] & ~run_prev;
  assign tick       = running_q && (cnt_q == CNT_LAST);

  // Undefined encodings fall back to COUNT on the next press.
  always_comb begin
    mode_nxt = M_COUNT;
    case (mode_q)
      M_COUNT:  mode_nxt = M_SHL;
      M_SHL:    mode_nxt = M_SHR;
      M_SHR:    mode_nxt = M_BOUNCE;
      M_BOUNCE: mode_nxt = M_BLINK;
      default:  mode_nxt = M_COUNT;
    endcase
  end

  always_comb begin
    led_init = '0;
    case (mode_nxt)
      M_SHL:    led_init = LED_ONE;
      M_SHR:    led_init = LED_MSB;
      M_BOUNCE: led_init = LED_ONE;
      default:  led_init = '0;
    endcase
  end

  // Bounce flips direction on the step that lands on an end bit, so each
  // end position is shown exactly once per turnaround.
  always_comb begin
    led_nxt = led_q;
    dir_nxt = dir_right_q;
    case (mode_q)
      M_COUNT: led_nxt = led_q + LED_ONE;
      M_SHL:   led_nxt = {led_q[N-2:0], led_q[N-1]};
      M_SHR:   led_nxt = {led_q[0], led_q[N-1:1]};
      M_BOUNCE: begin
        if (!dir_right_q) begin
          led_nxt = led_q << 1;
          if (led_q[N-2]) dir_nxt = 1'b1;
        end else begin
          led_nxt = led_q >> 1;
          if (led_q[1]) dir_nxt = 1'b0;
        end
      end
      M_BLINK: led_nxt = ~led_q;
      default: led_nxt = led_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_sync   <= '0;
      run_sync    <= '0;
      mode_prev   <= 1'b0;
      run_prev    <= 1'b0;
      mode_q      <= M_COUNT;
      led_q       <= '0;
      cnt_q       <= '0;
      dir_right_q <= 1'b0;
      running_q   <= 1'b1;
      step_q      <= 1'b0;
    end else begin
      mode_sync <= {mode_sync[0], btn_mode};
      run_sync  <= {run_sync[0], btn_run};
      mode_prev <= mode_sync[1];
      run_prev  <= run_sync[1];

      if (mode_press) begin
        mode_q      <= mode_nxt;
        led_q       <= led_init;
        cnt_q       <= '0;
        dir_right_q <= 1'b0;
        step_q      <= 1'b0;
      end else if (tick) begin
        cnt_q       <= '0;
        led_q       <= led_nxt;
        dir_right_q <= dir_nxt;
        step_q      <= 1'b1;
      end else begin
        if (running_q) cnt_q <= cnt_q + CNT_ONE;
        step_q <= 1'b0;
      end

      if (run_press) running_q <= ~running_q;
    end
  end

  assign led     = led_q;
  assign mode    = mode_q;
  assign running = running_q;
  assign step    = step_q;

endmodule

// File: tb/tb_led_effect_controller.sv
// Directed bench for led_effect_controller (N=8, TICK_DIV=4): walks every
// effect, pause/resume, mode-press/tick collision and asynchronous reset.
module tb_led_effect_controller;

  logic       clk;
  logic       reset;
  logic       btn_mode;
  logic       btn_run;
  logic [7:0] led;
  logic [2:0] mode;
  logic       running;
  logic       step;

  int total = 0;
  int bad   = 0;

  led_effect_controller #(.N(8), .TICK_DIV(4), .DIV_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_run  (btn_run),
    .led      (led),
    .mode     (mode),
    .running  (running),
    .step     (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Releases a held button long enough to re-arm edge detection, then presses it.
  task automatic rearm_mode();
    btn_mode = 1'b0;
    clk_n(2);
    btn_mode = 1'b1;
  endtask

  logic [7:0] bounce_tbl [15];

  initial begin
    bounce_tbl = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20,
                   8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    reset = 1'b1; btn_mode = 1'b0; btn_run = 1'b0;
    #3;
    chk("rst_led", led, 8'h00);
    chk("rst_mode", {5'd0, mode}, 8'd0);
    chk("rst_running", {7'd0, running}, 8'd1);
    chk("rst_step", {7'd0, step}, 8'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // COUNT: one increment per 4 clocks, full wrap
    clk_n(3);
    chk("cnt_pre_led", led, 8'h00);
    chk("cnt_pre_step", {7'd0, step}, 8'd0);
    clk_n(1);
    chk("cnt_first_led", led, 8'h01);
    chk("cnt_first_step", {7'd0, step}, 8'd1);
    clk_n(1);
    chk("cnt_step_low", {7'd0, step}, 8'd0);
    clk_n(3);
    chk("cnt_second_led", led, 8'h02);
    for (int i = 3; i <= 256; i++) begin
      clk_n(1);
      chk("cnt_step_gap", {7'd0, step}, 8'd0);
      clk_n(3);
      chk("cnt_led", led, 8'(i));
      chk("cnt_step", {7'd0, step}, 8'd1);
    end

    // First mode press: acts two edges after the input edge
    btn_mode = 1'b1;
    clk_n(1);
    chk("m1_k", {5'd0, mode}, 8'd0);
    clk_n(1);
    chk("m1_k1", {5'd0, mode}, 8'd0);
    clk_n(1);
    chk("m1_mode", {5'd0, mode}, 8'd1);
    chk("m1_led", led, 8'h01);
    chk("m1_step", {7'd0, step}, 8'd0);
    chk("m1_running", {7'd0, running}, 8'd1);
    for (int i = 1; i <= 8; i++) begin
      clk_n(4);
      chk("shl_led", led, 8'(1 << (i % 8)));
      chk("shl_step", {7'd0, step}, 8'd1);
    end
    chk("hold_no_press", {5'd0, mode}, 8'd1);

    // Second press lands one edge after a tick
    rearm_mode();
    clk_n(1);
    chk("m2_pre_led", led, 8'h01);
    clk_n(1);
    chk("m2_tick_led", led, 8'h02);
    chk("m2_tick_step", {7'd0, step}, 8'd1);
    clk_n(1);
    chk("m2_mode", {5'd0, mode}, 8'd2);
    chk("m2_led", led, 8'h80);
    chk("m2_step", {7'd0, step}, 8'd0);
    clk_n(4);
    chk("shr_led", led, 8'h40);
    chk("shr_step", {7'd0, step}, 8'd1);

    // Mode press exactly on a tick edge: tick discarded
    btn_mode = 1'b0;
    clk_n(5);
    chk("shr_led2", led, 8'h20);
    btn_mode = 1'b1;
    clk_n(2);
    chk("coll_pre_mode", {5'd0, mode}, 8'd2);
    chk("coll_pre_led", led, 8'h20);
    clk_n(1);
    chk("coll_mode", {5'd0, mode}, 8'd3);
    chk("coll_led", led, 8'h01);
    chk("coll_step", {7'd0, step}, 8'd0);
    clk_n(3);
    chk("coll_hold_led", led, 8'h01);
    chk("coll_hold_step", {7'd0, step}, 8'd0);
    clk_n(1);
    chk("bnc_first", led, 8'h02);
    chk("bnc_first_step", {7'd0, step}, 8'd1);
    for (int i = 0; i < 15; i++) begin
      clk_n(4);
      chk("bnc_led", led, bounce_tbl[i]);
    end

    // BLINK
    rearm_mode();
    clk_n(2);
    chk("m4_tick_led", led, 8'h08);
    clk_n(1);
    chk("m4_mode", {5'd0, mode}, 8'd4);
    chk("m4_led", led, 8'h00);
    clk_n(4);
    chk("blink1", led, 8'hFF);
    clk_n(4);
    chk("blink2", led, 8'h00);
    clk_n(4);
    chk("blink3", led, 8'hFF);

    // Run press on a tick edge: tick applied, then paused
    clk_n(1);
    btn_run = 1'b1;
    clk_n(2);
    chk("run_pre", {7'd0, running}, 8'd1);
    chk("run_pre_led", led, 8'hFF);
    clk_n(1);
    chk("run_tick_led", led, 8'h00);
    chk("run_tick_step", {7'd0, step}, 8'd1);
    chk("run_off", {7'd0, running}, 8'd0);
    for (int i = 0; i < 100; i++) begin
      clk_n(1);
      chk("pause_led", led, 8'h00);
      chk("pause_step", {7'd0, step}, 8'd0);
    end

    // Mode presses while paused
    rearm_mode();
    clk_n(2);
    chk("pm1_pre", {5'd0, mode}, 8'd4);
    clk_n(1);
    chk("pm1_mode", {5'd0, mode}, 8'd0);
    rearm_mode();
    clk_n(3);
    chk("pm2_mode", {5'd0, mode}, 8'd1);
    chk("pm2_led", led, 8'h01);
    chk("pm2_running", {7'd0, running}, 8'd0);
    for (int i = 0; i < 20; i++) begin
      clk_n(1);
      chk("pm_hold_led", led, 8'h01);
      chk("pm_hold_step", {7'd0, step}, 8'd0);
    end

    // Resume: first step exactly 4 clocks after the press edge
    btn_run = 1'b0;
    clk_n(2);
    btn_run = 1'b1;
    clk_n(2);
    chk("res_pre", {7'd0, running}, 8'd0);
    clk_n(1);
    chk("res_running", {7'd0, running}, 8'd1);
    chk("res_led", led, 8'h01);
    clk_n(3);
    chk("res_wait_led", led, 8'h01);
    chk("res_wait_step", {7'd0, step}, 8'd0);
    clk_n(1);
    chk("res_step_led", led, 8'h02);
    chk("res_step", {7'd0, step}, 8'd1);

    // Into BOUNCE, then asynchronous reset between edges
    rearm_mode();
    clk_n(3);
    chk("f_m2_mode", {5'd0, mode}, 8'd2);
    chk("f_m2_led", led, 8'h80);
    rearm_mode();
    clk_n(3);
    chk("f_m3_mode", {5'd0, mode}, 8'd3);
    chk("f_m3_led", led, 8'h01);
    clk_n(4);
    chk("f_bnc_led", led, 8'h02);
    btn_run = 1'b0;
    clk_n(1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_led", led, 8'h00);
    chk("ar_mode", {5'd0, mode}, 8'd0);
    chk("ar_running", {7'd0, running}, 8'd1);
    chk("ar_step", {7'd0, step}, 8'd0);
    reset = 1'b0;

    // Button held through reset release gives exactly one press
    clk_n(2);
    chk("held_pre_mode", {5'd0, mode}, 8'd0);
    clk_n(1);
    chk("held_mode", {5'd0, mode}, 8'd1);
    chk("held_led", led, 8'h01);
    chk("held_running", {7'd0, running}, 8'd1);
    clk_n(20);
    chk("held_once", {5'd0, mode}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_effect_controller.md
Name: led_effect_controller

Overview:
- Sequencer for the 8-LED effect board. Holds the LED pattern register and advances it once per prescaled tick.
- The pattern rule depends on the selected effect mode. Two buttons control it: one cycles the effect mode, the other toggles run/pause.
- Sits between the board buttons (already debounced externally) and the LED pins. Replaces direct button-clocking of the LED counter, so the whole block runs on the single system clock.

Parameters:
- N, 8: LED count / pattern width (N >= 2).
- TICK_DIV, 12500000: clk cycles per pattern step (4 Hz at 50 MHz). Legal range >= 2.
- DIV_W, 24: prescaler width. Must satisfy 2^DIV_W > TICK_DIV - 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- btn_mode  in  1  raw (debounced, asynchronous) mode button, active-high.
- btn_run  in  1  raw (debounced, asynchronous) run/pause button, active-high.
- led  out  N  current LED pattern (registered).
- mode  out  3  current effect: 0 COUNT, 1 SHL, 2 SHR, 3 BOUNCE, 4 BLINK.
- running  out  1  1 = stepping enabled.
- step  out  1  one-cycle pulse, high in the cycle after led advances on a tick.

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk. All state is on the rising edge of clk.
- Reset values: led=0, mode=0 (COUNT), running=1, step=0, prescaler cnt=0, bounce dir=left, synchronizer and edge registers=0.
- Button inputs: each button passes a 2-flop synchronizer, then rising-edge detect (sync2 & ~prev), giving a 1-cycle press pulse.
  - Input rising before edge k: the press acts at edge k+2; led/mode/running are visible after edge k+2.
  - A button held through reset release yields exactly one press.
  - Holding a button produces no further presses.
- Prescaler:
  - Running, no mode press: cnt increments each cycle. At cnt==TICK_DIV-1, cnt wraps to 0, led<=next(led), and step<=1 next cycle. Otherwise step<=0.
  - Paused: cnt and led hold; step=0.
- Mode press:
  - mode <= (mode==4) ? 0 : mode+1.
  - led loads the new mode's initial pattern; cnt<=0; step<=0; dir<=left.
  - running is unchanged, so a press while paused reloads the pattern and stays paused.
- Run press: running <= ~running.
- Effect next-state rules and initial patterns:
  - COUNT: led+1 modulo 2^N. 0xFF -> 0x00. Init 0.
  - SHL: rotate left, MSB wraps to LSB. Init 1.
  - SHR: rotate right, LSB wraps to MSB. Init 1<<(N-1).
  - BOUNCE: single lit bit. dir=left shifts left; on reaching the MSB, dir becomes right, and the MSB step is followed by a right shift. Symmetric at the LSB. Period 2N-2 steps. Init 1, dir left.
  - BLINK: led <= ~led. Init 0, so the first tick gives all ones.
- Simultaneous events:
  - Mode press + tick in the same cycle: mode press wins. Tick discarded, cnt cleared, step=0.
  - Run press + tick in the same cycle (running=1): tick is applied (led advances, step pulses), and running becomes 0 at the same edge.
  - Run press + mode press in the same cycle: both take effect.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). Stepping resumes in COUNT from 0 after release.
- Undefined mode encodings 5-7 are unreachable. If ever present, the next mode press goes to 0 and led holds on a tick.

Test Plan (N=8, TICK_DIV=4):
- Reset release, no buttons -> led 0x00,0x01,0x02,... one increment per 4 clks; step high exactly 1 cycle after each change; after 256 steps led wraps to 0x00.
- One btn_mode press -> mode=1, led=0x01 at edge k+2; then 0x02,0x04,...,0x80,0x01 every 4 clks. Second press -> mode=2, led=0x80, then 0x40.
- Three presses from reset -> mode=3 BOUNCE. Sequence 0x01,0x02,...,0x80,0x40,...,0x01,0x02 (period 14 steps); 0x80 and 0x01 each appear once per turnaround.
- Four presses from reset -> BLINK: led 0x00 -> 0xFF -> 0x00 per tick. Fifth press -> mode=0, led=0x00.
- btn_run press -> running=0; led and cnt frozen for 100 clks; step never pulses; mode press while paused loads the init pattern and running stays 0. Second run press -> resumes, first step exactly 4 clks later.
- Timing the mode press to coincide with cnt==3 -> no advance and no step; led = new init, cnt=0. Asserting reset mid-BOUNCE -> led=0x00, mode=0, running=1 without a clock edge.
